// File: rtl/spi_sched_if.sv
// spi_sched_if: requester-side and flex_spi-side signals of the spi_sched
// round-robin SPI scheduler, bundled into one interface.
//
// Modports:
//   master - used by spi_sched: drives grant/rsp_*/cs_n/spi_* strobes and mode,
//            observes req/req_tx/req_cfg and the flex_spi status and data bus.
//   slave  - used by the environment (requesters plus flex_spi).
//
// Signals:
//   req[NREQ]          level request per requester
//   req_tx[16*NREQ]    TX word of requester i at [16i+15:16i]
//   req_cfg[6*NREQ]    requester i: [6i+5]=cpol, [6i+4]=cpha, [6i+3:6i]=xfer_len
//   grant[NREQ]        one-hot owner of the SPI master
//   rsp_valid[NREQ]    one-cycle response pulse to the owner
//   rsp_data[16]       RX word, valid with rsp_valid
//   rsp_err            timeout abort flag, valid with rsp_valid
//   cs_n[NREQ]         active-low chip selects
//   spi_we/en/oe       strobes to flex_spi
//   spi_cpol/cpha      mode to flex_spi
//   spi_xfer_len[4]    transfer length to flex_spi
//   spi_tx[16]         word driven onto the flex_spi data bus while spi_we=1
//   spi_rx[16]         flex_spi data bus, sampled while spi_oe=1
//   spi_busy/spi_done  flex_spi status
interface spi_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   req_tx;
  logic [6*NREQ-1:0]    req_cfg;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      rsp_valid;
  logic [15:0]          rsp_data;
  logic                 rsp_err;
  logic [NREQ-1:0]      cs_n;
  logic                 spi_we;
  logic                 spi_en;
  logic                 spi_oe;
  logic                 spi_cpol;
  logic                 spi_cpha;
  logic [3:0]           spi_xfer_len;
  logic [15:0]          spi_tx;
  logic [15:0]          spi_rx;
  logic                 spi_busy;
  logic                 spi_done;

  modport master (
    input  req, req_tx, req_cfg, spi_rx, spi_busy, spi_done,
    output grant, rsp_valid, rsp_data, rsp_err, cs_n,
           spi_we, spi_en, spi_oe, spi_cpol, spi_cpha, spi_xfer_len, spi_tx
  );

  modport slave (
    output req, req_tx, req_cfg, spi_rx, spi_busy, spi_done,
    input  grant, rsp_valid, rsp_data, rsp_err, cs_n,
           spi_we, spi_en, spi_oe, spi_cpol, spi_cpha, spi_xfer_len, spi_tx
  );
endinterface

// File: rtl/spi_sched.sv
// spi_sched: round-robin scheduler sharing one flex_spi master among NREQ
// requesters. Sequences IDLE -> LOAD -> SETUP -> XFER -> READ -> RESP -> IDLE,
// drives per-requester chip selects and returns the RX word to the owner.
//
// Parameters:
//   NREQ    number of requesters (2..8)
//   TIMEOUT XFER watchdog limit in clk cycles (16..65535), only used when the
//           SPI_SCHED_TIMEOUT_EN macro is defined.
//
// Ports:
//   clk  system clock, shared with flex_spi
//   rst  synchronous active-high reset
//   bus  spi_sched_if.master (requester handshake plus flex_spi strobes)
//
// Build option:
//   SPI_SCHED_TIMEOUT_EN  defined: XFER aborts after TIMEOUT cycles with
//                         rsp_err=1 and rsp_data=16'hFFFF.
//                         undefined: XFER waits indefinitely, rsp_err is 0.
module spi_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic         clk,
  input logic         rst,
  spi_sched_if.master bus
);
  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("spi_sched: NREQ must be in 2..8");
  end
  if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("spi_sched: TIMEOUT must be in 16..65535");
  end

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, XFER, READ, RESP} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   owner, owner_d, ptr, ptr_d, win;
  logic            busy_seen, busy_seen_d;
  logic [NREQ-1:0] grant_q, grant_d, rsp_valid_q, rsp_valid_d, cs_n_q, cs_n_d;
  logic [15:0]     rsp_data_q, rsp_data_d, tx_q, tx_d;
  logic            cpol_q, cpol_d, cpha_q, cpha_d;
  logic [3:0]      len_q, len_d;
  logic            we_q, we_d, en_q, en_d, oe_q, oe_d;
`ifdef SPI_SCHED_TIMEOUT_EN
  logic [15:0]     cnt, cnt_d;
  logic            err_q, err_d;
`endif

  // First requesting index strictly after ptr, wrapping; scanning from the
  // far end down lets the nearest index overwrite farther ones.
  always_comb begin
    int unsigned idx;
    idx = 0;
    win = ptr;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      idx = (32'(ptr) + k) % NREQ;
      if (bus.req[idx]) win = IW'(idx);
    end
  end

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    ptr_d       = ptr;
    busy_seen_d = busy_seen;
    tx_d        = tx_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    len_d       = len_q;
    rsp_data_d  = rsp_data_q;
`ifdef SPI_SCHED_TIMEOUT_EN
    cnt_d       = cnt;
    err_d       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_d = LOAD;
          owner_d = win;
          ptr_d   = win;
          tx_d    = bus.req_tx[16*win +: 16];
          {cpol_d, cpha_d, len_d} = bus.req_cfg[6*win +: 6];
        end
      end
      LOAD:  state_d = SETUP;
      SETUP: begin
        state_d     = XFER;
        busy_seen_d = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      XFER: begin
        if (bus.spi_busy) busy_seen_d = 1'b1;
        // A done without a prior busy belongs to the previous transfer.
        if (bus.spi_done && busy_seen) state_d = READ;
`ifdef SPI_SCHED_TIMEOUT_EN
        else if (cnt == 16'(TIMEOUT - 1)) begin
          state_d    = RESP;
          rsp_data_d = '1;
          err_d      = 1'b1;
        end
        cnt_d = cnt + 16'd1;
`endif
      end
      READ: begin
        rsp_data_d = bus.spi_rx;
        state_d    = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    grant_d     = '0;
    rsp_valid_d = '0;
    cs_n_d      = '1;
    if (state_d != IDLE) grant_d[owner_d] = 1'b1;
    if (state_d inside {SETUP, XFER, READ}) cs_n_d[owner_d] = 1'b0;
    if (state_d == RESP) rsp_valid_d[owner_d] = 1'b1;
    we_d = (state_d == LOAD);
    en_d = (state_d == XFER);
    oe_d = (state_d == READ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= IW'(NREQ - 1);
      busy_seen   <= 1'b0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      cs_n_q      <= '1;
      rsp_data_q  <= '0;
      tx_q        <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      len_q       <= '0;
      we_q        <= 1'b0;
      en_q        <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      ptr         <= ptr_d;
      busy_seen   <= busy_seen_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      cs_n_q      <= cs_n_d;
      rsp_data_q  <= rsp_data_d;
      tx_q        <= tx_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      len_q       <= len_d;
      we_q        <= we_d;
      en_q        <= en_d;
      oe_q        <= oe_d;
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.grant        = grant_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.cs_n         = cs_n_q;
  assign bus.spi_we       = we_q;
  assign bus.spi_en       = en_q;
  assign bus.spi_oe       = oe_q;
  assign bus.spi_cpol     = cpol_q;
  assign bus.spi_cpha     = cpha_q;
  assign bus.spi_xfer_len = len_q;
  assign bus.spi_tx       = tx_q;
endmodule

// File: tb/tb_spi_sched.sv
// tb_spi_sched: self-checking bench for spi_sched. The scheduler's expected
// behaviour comes from a round-robin pick over the request mask plus fixed
// per-phase cycle counts; flex_spi is played by directed busy/done/data steps.
module tb_spi_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_sched_if #(.NREQ(NREQ)) bus ();
  spi_sched #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [15:0] tx   [NREQ];
  logic        cpol [NREQ];
  logic        cpha [NREQ];
  logic [3:0]  len  [NREQ];
  int unsigned mptr;
  logic [NREQ-1:0] all1 = '1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int unsigned i = 0; i < NREQ; i++) begin
      bus.req_tx[16*i +: 16] = tx[i];
      bus.req_cfg[6*i +: 6]  = {cpol[i], cpha[i], len[i]};
    end
  endtask

  task automatic shuffle_cfg();
    for (int unsigned i = 0; i < NREQ; i++) begin
      tx[i]   = 16'($urandom);
      cpol[i] = 1'($urandom_range(0, 1));
      cpha[i] = 1'($urandom_range(0, 1));
      len[i]  = 4'($urandom_range(0, 15));
    end
    apply_cfg();
  endtask

  // Reference arbitration: first set request after the last winner, wrapping.
  function automatic int unsigned rr_pick(input logic [NREQ-1:0] r, input int unsigned p);
    for (int unsigned k = 1; k <= NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return p;
  endfunction

  task automatic chk_cfg(input string ph, input logic [15:0] t, input logic po,
                         input logic ph_a, input logic [3:0] l);
    chk({ph, "_spi_tx"}, bus.spi_tx, t);
    chk({ph, "_cpol"}, bus.spi_cpol, po);
    chk({ph, "_cpha"}, bus.spi_cpha, ph_a);
    chk({ph, "_len"}, bus.spi_xfer_len, l);
  endtask

  // Called at a negedge with the DUT idle and req already set; returns at
  // the negedge of the following IDLE cycle.
  task automatic serve(input logic [15:0] rx, input int unsigned blen, input bit stale,
                       input logic [NREQ-1:0] drop_xfer, input logic [NREQ-1:0] drop_resp,
                       input logic [NREQ-1:0] add_resp, input bit shuffle);
    int unsigned o;
    logic [NREQ-1:0] oh, cs_own;
    logic [15:0] s_tx;
    logic s_cpol, s_cpha;
    logic [3:0] s_len;
    o = rr_pick(bus.req, mptr);
    mptr = o;
    oh = '0;
    oh[o] = 1'b1;
    cs_own = ~oh;
    s_tx = tx[o]; s_cpol = cpol[o]; s_cpha = cpha[o]; s_len = len[o];

    @(negedge clk); // LOAD
    chk("load_we", bus.spi_we, 1'b1);
    chk("load_grant", bus.grant, oh);
    chk("load_cs_n", bus.cs_n, all1);
    chk("load_en", bus.spi_en, 1'b0);
    chk_cfg("load", s_tx, s_cpol, s_cpha, s_len);
    if (stale) bus.spi_done = 1'b1;

    @(negedge clk); // SETUP
    chk("setup_we", bus.spi_we, 1'b0);
    chk("setup_en", bus.spi_en, 1'b0);
    chk("setup_cs_n", bus.cs_n, cs_own);
    chk("setup_grant", bus.grant, oh);

    @(negedge clk); // first XFER cycle
    chk("xfer_en", bus.spi_en, 1'b1);
    chk("xfer_cs_n", bus.cs_n, cs_own);
    chk("xfer_oe", bus.spi_oe, 1'b0);
    if (stale) begin
      repeat (3) begin
        @(negedge clk);
        chk("stale_en", bus.spi_en, 1'b1);
        chk("stale_oe", bus.spi_oe, 1'b0);
      end
      bus.spi_done = 1'b0;
    end
    bus.req = bus.req & ~drop_xfer;
    if (shuffle) shuffle_cfg();
    bus.spi_busy = 1'b1;
    for (int unsigned i = 0; i < blen; i++) begin
      @(negedge clk);
      chk("busy_en", bus.spi_en, 1'b1);
      chk("busy_cs_n", bus.cs_n, cs_own);
      chk_cfg("busy", s_tx, s_cpol, s_cpha, s_len);
    end
    bus.spi_busy = 1'b0;
    bus.spi_done = 1'b1;

    @(negedge clk); // READ
    chk("read_oe", bus.spi_oe, 1'b1);
    chk("read_en", bus.spi_en, 1'b0);
    chk("read_cs_n", bus.cs_n, cs_own);
    chk("read_rsp_valid", bus.rsp_valid, '0);
    bus.spi_done = 1'b0;
    bus.spi_rx   = rx;

    @(negedge clk); // RESP
    chk("resp_valid", bus.rsp_valid, oh);
    chk("resp_data", bus.rsp_data, rx);
    chk("resp_err", bus.rsp_err, 1'b0);
    chk("resp_cs_n", bus.cs_n, all1);
    chk("resp_grant", bus.grant, oh);
    chk("resp_oe", bus.spi_oe, 1'b0);
    chk_cfg("resp", s_tx, s_cpol, s_cpha, s_len);
    bus.spi_rx = 16'($urandom);
    bus.req = (bus.req & ~drop_resp) | add_resp;

    @(negedge clk); // IDLE
    chk("idle_grant", bus.grant, '0);
    chk("idle_rsp_valid", bus.rsp_valid, '0);
    chk("idle_cs_n", bus.cs_n, all1);
    chk("idle_we", bus.spi_we, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] oh;
    int unsigned o;

    rst = 1'b1;
    bus.req = '0;
    bus.spi_busy = 1'b0;
    bus.spi_done = 1'b0;
    bus.spi_rx = 16'h0;
    shuffle_cfg();
    repeat (3) @(negedge clk);
    chk("rst_cs_n", bus.cs_n, all1);
    chk("rst_grant", bus.grant, '0);
    chk("rst_rsp_valid", bus.rsp_valid, '0);
    chk("rst_rsp_data", bus.rsp_data, 16'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_we_en_oe", {bus.spi_we, bus.spi_en, bus.spi_oe}, 3'b000);
    chk_cfg("rst", 16'h0, 1'b0, 1'b0, 4'h0);
    mptr = NREQ - 1;
    rst = 1'b0;

    // All requesters held: eight fair grants starting at index 0.
    bus.req = '1;
    for (int unsigned t = 0; t < 8; t++)
      serve(16'($urandom), $urandom_range(1, 6), 1'b0, '0, (t == 7) ? all1 : '0, '0, 1'b0);

    // Single directed request.
    tx[0] = 16'hA55A; cpol[0] = 1'b0; cpha[0] = 1'b1; len[0] = 4'd8;
    apply_cfg();
    bus.req = 4'b0001;
    serve(16'h003C, 8, 1'b0, '0, 4'b0001, '0, 1'b0);

    // Stale done on XFER entry must not end the transfer.
    bus.req = 4'b0010;
    serve(16'($urandom), 3, 1'b1, '0, 4'b0010, '0, 1'b0);

    // Requester 2 withdraws during XFER; requester 3 follows.
    bus.req = 4'b1100;
    serve(16'($urandom), 4, 1'b0, 4'b0100, '0, '0, 1'b0);
    serve(16'($urandom), 2, 1'b0, '0, 4'b1000, '0, 1'b0);

    // Reset in the third XFER cycle.
    bus.req = 4'b0100;
    o = rr_pick(bus.req, mptr);
    oh = '0;
    oh[o] = 1'b1;
    @(negedge clk);
    chk("rstx_load_grant", bus.grant, oh);
    repeat (3) @(negedge clk);
    chk("rstx_in_xfer", bus.spi_en, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    chk("rstx_cs_n", bus.cs_n, all1);
    chk("rstx_en", bus.spi_en, 1'b0);
    chk("rstx_grant", bus.grant, '0);
    chk("rstx_rsp_valid", bus.rsp_valid, '0);
    rst = 1'b0;
    mptr = NREQ - 1;
    bus.req = '1;
    serve(16'($urandom), 2, 1'b0, '0, all1, '0, 1'b0);

`ifdef SPI_SCHED_TIMEOUT_EN
    bus.req = 4'b0010;
    o = rr_pick(bus.req, mptr);
    mptr = o;
    oh = '0;
    oh[o] = 1'b1;
    repeat (3) @(negedge clk);
    chk("tmo_xfer_entry", bus.spi_en, 1'b1);
    for (int unsigned i = 1; i < TMO; i++) begin
      @(negedge clk);
      chk("tmo_wait_valid", bus.rsp_valid, '0);
      chk("tmo_wait_en", bus.spi_en, 1'b1);
    end
    @(negedge clk);
    chk("tmo_valid", bus.rsp_valid, oh);
    chk("tmo_err", bus.rsp_err, 1'b1);
    chk("tmo_data", bus.rsp_data, 16'hFFFF);
    chk("tmo_en", bus.spi_en, 1'b0);
    chk("tmo_oe", bus.spi_oe, 1'b0);
    bus.req = '0;
    @(negedge clk);
    chk("tmo_err_clear", bus.rsp_err, 1'b0);
`endif

    // Random masks, withdrawals, late arrivals and config changes mid-transfer.
    for (int unsigned t = 0; t < 16; t++) begin
      if (bus.req == '0) bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      serve(16'($urandom), $urandom_range(1, 8), 1'($urandom_range(0, 1)),
            NREQ'($urandom), (t == 15) ? all1 : NREQ'($urandom),
            (t == 15) ? '0 : NREQ'($urandom), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
